// File: rtl/nx_fifo_wr_arb.sv
// nx_fifo_wr_arb: round-robin write arbiter feeding a downstream FIFO.
// N_REQ requesters compete for the FIFO write port. A grant lasts until a
// packet ends, MAX_BURST beats have been accepted, or the holder drops valid.
// Accepted beats reach the FIFO one cycle later through registered outputs.
// sw_clear diverts the FSM through a one-cycle FLUSH that pulses fifo_clear.
module nx_fifo_wr_arb #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4,
  localparam int SW       = $clog2(DEPTH) + 1,
  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   sw_clear,
  input  logic                   fifo_full,
  input  logic [SW-1:0]          fifo_free_slots,
  output logic                   fifo_wen,
  output logic [WIDTH-1:0]       fifo_wdata,
  output logic                   fifo_clear,
  output logic [IW-1:0]          grant_id,
  output logic                   busy,
  output logic                   err_overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [3:0]       beat_q, beat_d;
  logic             fifo_wen_q;
  logic [WIDTH-1:0] fifo_wdata_q;
  logic             fifo_clear_q;
  logic             err_q;

  logic [IW-1:0]    pick_s;
  logic             pick_vld_s;
  logic             room_s;
  logic [N_REQ-1:0] ready_s;
  logic             accept_s;
  logic             hold_valid_s;
  logic             hold_last_s;
  logic [WIDTH-1:0] hold_data_s;
  logic             burst_done_s;

  // Round-robin search: first valid requester after rr_ptr, wrapping at N_REQ-1.
  always_comb begin
    int idx_v;
    pick_s     = '0;
    pick_vld_s = 1'b0;
    idx_v      = 0;
    // Scan from the farthest candidate down so the nearest one wins last.
    for (int k = N_REQ; k >= 1; k--) begin
      idx_v = int'(rr_ptr_q) + k;
      if (idx_v >= N_REQ) begin
        idx_v = idx_v - N_REQ;
      end else begin
        idx_v = idx_v;
      end
      if (req_valid[IW'(idx_v)]) begin
        pick_s     = IW'(idx_v);
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Room check counts the beat already in flight on fifo_wen.
  assign room_s       = (fifo_free_slots > {{(SW-1){1'b0}}, fifo_wen_q});
  assign hold_valid_s = req_valid[grant_q];
  assign hold_last_s  = req_last[grant_q];
  assign hold_data_s  = req_data[int'(grant_q)*WIDTH +: WIDTH];
  assign burst_done_s = (beat_q == 4'(MAX_BURST - 1));

  // Only the grant holder sees ready, and only while granted, not clearing, and with room.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ready_s[i] = (state_q == ST_GRANT) && !sw_clear && (grant_q == IW'(i)) &&
                   req_valid[i] && room_s && !fifo_full;
    end
  end

  assign accept_s = |ready_s;

  // Next-state logic for the FSM, grant holder, round-robin pointer and beat count.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (sw_clear) begin
          state_d = ST_FLUSH;
        end else if (pick_vld_s) begin
          state_d = ST_GRANT;
          grant_d = pick_s;
          beat_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (sw_clear) begin
          state_d = ST_FLUSH;
        end else if (accept_s) begin
          beat_d = beat_q + 4'd1;
          if (hold_last_s || burst_done_s) begin
            state_d  = ST_IDLE;
            rr_ptr_d = grant_q;
          end else begin
            state_d = ST_GRANT;
          end
        end else if (!hold_valid_s) begin
          state_d  = ST_IDLE;
          rr_ptr_d = grant_q;
        end else begin
          // Valid but blocked by a full FIFO or no free slot: keep holding.
          state_d = ST_GRANT;
        end
      end
      ST_FLUSH: begin
        // Always pass through IDLE so a held sw_clear pulses every other cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; rst wins over sw_clear and in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= IW'(N_REQ - 1);
      grant_q      <= '0;
      beat_q       <= 4'd0;
      fifo_wen_q   <= 1'b0;
      fifo_wdata_q <= '0;
      fifo_clear_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      beat_q       <= beat_d;
      fifo_wen_q   <= accept_s;
      if (accept_s) begin
        fifo_wdata_q <= hold_data_s;
      end
      fifo_clear_q <= (state_d == ST_FLUSH);
      if (fifo_wen_q && fifo_full) begin
        err_q <= 1'b1;
      end
    end
  end

  assign req_ready    = ready_s;
  assign fifo_wen     = fifo_wen_q;
  assign fifo_wdata   = fifo_wdata_q;
  assign fifo_clear   = fifo_clear_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// Directed testbench for nx_fifo_wr_arb with default parameters.
module tb_nx_fifo_wr_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         sw_clear;
  logic         fifo_full;
  logic [4:0]   fifo_free_slots;
  logic         fifo_wen;
  logic [63:0]  fifo_wdata;
  logic         fifo_clear;
  logic [1:0]   grant_id;
  logic         busy;
  logic         err_overflow;

  int checks   = 0;
  int failures = 0;
  int order [5] = '{0, 1, 2, 3, 0};

  nx_fifo_wr_arb #(
    .N_REQ(4), .WIDTH(64), .DEPTH(16), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .sw_clear(sw_clear), .fifo_full(fifo_full),
    .fifo_free_slots(fifo_free_slots), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .fifo_clear(fifo_clear), .grant_id(grant_id),
    .busy(busy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge to a stable sampling point.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'd0; req_data = '0; req_last = 4'd0;
    sw_clear = 1'b0; fifo_full = 1'b0; fifo_free_slots = 5'd16;

    // Reset values
    cyc(); cyc();
    chk("rst_wen",   64'(fifo_wen), 64'd0);
    chk("rst_wdata", fifo_wdata, 64'd0);
    chk("rst_clear", 64'(fifo_clear), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_err",   64'(err_overflow), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // Single requester 0, three beats, last on third
    req_valid = 4'b0001; req_data[0 +: 64] = 64'hA1;
    #1 chk("t1_idle_ready", 64'(req_ready), 64'd0);
    cyc();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_grant", 64'(grant_id), 64'd0);
    chk("t1_wen0", 64'(fifo_wen), 64'd0);
    chk("t1_ready", 64'(req_ready), 64'b0001);
    cyc();
    chk("t1_wen1", 64'(fifo_wen), 64'd1);
    chk("t1_data1", fifo_wdata, 64'hA1);
    req_data[0 +: 64] = 64'hA2;
    cyc();
    chk("t1_wen2", 64'(fifo_wen), 64'd1);
    chk("t1_data2", fifo_wdata, 64'hA2);
    req_data[0 +: 64] = 64'hA3; req_last = 4'b0001;
    cyc();
    chk("t1_wen3", 64'(fifo_wen), 64'd1);
    chk("t1_data3", fifo_wdata, 64'hA3);
    chk("t1_idle", 64'(busy), 64'd0);
    req_valid = 4'd0; req_last = 4'd0;
    cyc();
    chk("t1_wen_off", 64'(fifo_wen), 64'd0);

    // Reset, then all four requesters valid with endless packets
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'h1000 + 64'(i);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("t2_busy", 64'(busy), 64'd1);
      chk("t2_grant", 64'(grant_id), 64'(order[n]));
      chk("t2_arb_wen", 64'(fifo_wen), 64'd0);
      for (int b = 0; b < 4; b++) begin
        cyc();
        chk("t2_wen", 64'(fifo_wen), 64'd1);
        chk("t2_data", fifo_wdata, 64'h1000 + 64'(order[n]));
        chk("t2_busy_b", 64'(busy), (b < 3) ? 64'd1 : 64'd0);
      end
    end
    req_valid = 4'd0;
    cyc();

    // Free-slot backpressure on requester 1 (rr_ptr now 0)
    req_valid = 4'b0010; req_data[64 +: 64] = 64'hB1;
    cyc();
    chk("t3_grant", 64'(grant_id), 64'd1);
    fifo_free_slots = 5'd1;
    #1 chk("t3_ready1", 64'(req_ready), 64'b0010);
    cyc();
    chk("t3_wen", 64'(fifo_wen), 64'd1);
    chk("t3_data", fifo_wdata, 64'hB1);
    chk("t3_blocked", 64'(req_ready), 64'd0);
    chk("t3_held", 64'(busy), 64'd1);
    fifo_free_slots = 5'd2; req_data[64 +: 64] = 64'hB2;
    #1 chk("t3_resume", 64'(req_ready), 64'b0010);
    cyc();
    chk("t3_wen2", 64'(fifo_wen), 64'd1);
    chk("t3_data2", fifo_wdata, 64'hB2);
    req_valid = 4'd0; fifo_free_slots = 5'd16;
    cyc();
    chk("t3_end_busy", 64'(busy), 64'd0);
    chk("t3_end_wen", 64'(fifo_wen), 64'd0);

    // sw_clear on beat 2 of requester 2 (rr_ptr now 1)
    req_valid = 4'b0100; req_data[128 +: 64] = 64'hC1;
    cyc();
    chk("t4_grant", 64'(grant_id), 64'd2);
    cyc();
    chk("t4_wen1", 64'(fifo_wen), 64'd1);
    chk("t4_data1", fifo_wdata, 64'hC1);
    sw_clear = 1'b1; req_data[128 +: 64] = 64'hC2;
    #1 chk("t4_ready_kill", 64'(req_ready), 64'd0);
    cyc();
    chk("t4_clear", 64'(fifo_clear), 64'd1);
    chk("t4_no_wen", 64'(fifo_wen), 64'd0);
    chk("t4_ready", 64'(req_ready), 64'd0);
    chk("t4_grant_keep", 64'(grant_id), 64'd2);
    sw_clear = 1'b0; req_valid = 4'd0;
    cyc();
    chk("t4_clear_off", 64'(fifo_clear), 64'd0);
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_grant_after", 64'(grant_id), 64'd2);

    // Held sw_clear pulses fifo_clear every other cycle
    sw_clear = 1'b1;
    cyc();
    chk("t5_pulse1", 64'(fifo_clear), 64'd1);
    cyc();
    chk("t5_gap", 64'(fifo_clear), 64'd0);
    chk("t5_gap_busy", 64'(busy), 64'd0);
    cyc();
    chk("t5_pulse2", 64'(fifo_clear), 64'd1);
    sw_clear = 1'b0;
    cyc();
    chk("t5_done", 64'(fifo_clear), 64'd0);

    // Overflow: fifo_full while fifo_wen high, requester 3 (rr_ptr still 1)
    req_valid = 4'b1000; req_data[192 +: 64] = 64'hE1;
    cyc();
    chk("t6_grant", 64'(grant_id), 64'd3);
    cyc();
    chk("t6_wen", 64'(fifo_wen), 64'd1);
    fifo_full = 1'b1;
    #1 chk("t6_ready_full", 64'(req_ready), 64'd0);
    chk("t6_err_pre", 64'(err_overflow), 64'd0);
    cyc();
    chk("t6_err_set", 64'(err_overflow), 64'd1);
    chk("t6_wen_off", 64'(fifo_wen), 64'd0);
    fifo_full = 1'b0; req_valid = 4'd0;
    cyc();
    chk("t6_err_sticky", 64'(err_overflow), 64'd1);
    chk("t6_idle", 64'(busy), 64'd0);

    // Reset during GRANT with a beat offered (rr_ptr now 3 -> requester 1)
    req_valid = 4'b0010; req_data[64 +: 64] = 64'hF1;
    cyc();
    chk("t7_grant", 64'(grant_id), 64'd1);
    chk("t7_ready", 64'(req_ready), 64'b0010);
    rst = 1'b1;
    cyc();
    chk("t7_wen", 64'(fifo_wen), 64'd0);
    chk("t7_wdata", fifo_wdata, 64'd0);
    chk("t7_clear", 64'(fifo_clear), 64'd0);
    chk("t7_grant0", 64'(grant_id), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_err", 64'(err_overflow), 64'd0);
    chk("t7_ready0", 64'(req_ready), 64'd0);
    rst = 1'b0; req_valid = 4'd0;
    cyc();
    chk("t7_wen_after", 64'(fifo_wen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nx_fifo_wr_arb.md
NX_FIFO_WR_ARB -- requirements
Module: nx_fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of write requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 64, giving the data width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16, giving the depth of the downstream FIFO; SW = $clog2(DEPTH)+1.
REQ-004 The block SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant (1..15).
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  N_REQ  per-requester beat valid.
REQ-008 req_data  input  N_REQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_last  input  N_REQ  per-requester end-of-packet flag, qualified by req_valid.
REQ-010 req_ready  output  N_REQ  per-requester beat accept; beat transfers when valid & ready.
REQ-011 sw_clear  input  1  software flush request.
REQ-012 fifo_full  input  1  FIFO full flag.
REQ-013 fifo_free_slots  input  SW  FIFO free-slot count.
REQ-014 fifo_wen  output  1  FIFO write enable, registered.
REQ-015 fifo_wdata  output  WIDTH  FIFO write data, registered.
REQ-016 fifo_clear  output  1  FIFO clear pulse, registered.
REQ-017 grant_id  output  $clog2(N_REQ)  index of current grant holder.
REQ-018 busy  output  1  high while state is not IDLE.
REQ-019 err_overflow  output  1  sticky error, set on a write issued while fifo_full.

Function
REQ-020 The FSM SHALL have states IDLE, GRANT and FLUSH.
REQ-021 In IDLE with any req_valid high, the block SHALL choose the first requester with req_valid high, searching round-robin from rr_ptr+1 modulo N_REQ, and SHALL enter GRANT on the next cycle with grant_id set to that index.
REQ-022 rr_ptr SHALL update to grant_id when the grant ends, so the last holder has lowest priority next.
REQ-023 Only the grant holder's req_ready SHALL be driven, and only in GRANT; req_ready[g] = req_valid[g] & (fifo_free_slots > fifo_wen) & !fifo_full, combinational.
REQ-024 Each accepted beat SHALL appear on fifo_wen/fifo_wdata exactly one cycle later (latency 1).
REQ-025 The beat counter SHALL clear on grant and increment per accepted beat.
REQ-026 The grant SHALL end, returning to IDLE, on the cycle after accepting a beat with req_last=1, or after the MAX_BURST-th accepted beat, or when the holder deasserts req_valid with no beat accepted.
REQ-027 No IDLE cycle SHALL be skipped: re-arbitration takes one cycle, so a requester receives at most MAX_BURST consecutive beats.
REQ-028 When fifo_free_slots <= fifo_wen, req_ready SHALL stay low and the grant SHALL be held, with no timeout.
REQ-029 sw_clear in any state SHALL move the FSM to FLUSH next cycle, force req_ready low, and suppress any fifo_wen not already registered.
REQ-030 FLUSH SHALL assert fifo_clear for exactly one cycle, then return to IDLE; rr_ptr is unchanged.
REQ-031 If sw_clear is held high, FLUSH SHALL repeat the one-cycle fifo_clear pulse every other cycle, until sw_clear drops.
REQ-032 If fifo_wen is asserted while fifo_full=1, err_overflow SHALL be set and remain set until rst.
REQ-033 For N_REQ not a power of 2, the round-robin search SHALL wrap at N_REQ-1 to 0.

Reset
REQ-034 When rst=1 on a clock edge, the next state SHALL be: FSM=IDLE, rr_ptr=N_REQ-1 (first search starts at requester 0), beat counter=0, fifo_wen=0, fifo_wdata=0, fifo_clear=0, grant_id=0, busy=0, err_overflow=0, req_ready=0.
REQ-035 rst SHALL override sw_clear and any transfer in progress; a beat accepted in the reset cycle is discarded.

Verification
REQ-036 Single requester 0 sends 3 beats, last on beat 3, into an empty FIFO -> fifo_wen high for 3 consecutive cycles starting 1 cycle after the first accept, data in order, then IDLE.
REQ-037 All 4 requesters continuously valid with long packets, MAX_BURST=4 -> grant order 0,1,2,3,0; each grant gives exactly 4 beats; one idle arbitration cycle between grants.
REQ-038 fifo_free_slots=1 and a beat is accepted -> the next cycle req_ready=0 (free_slots=1, fifo_wen=1); accepts resume when free_slots=2.
REQ-039 sw_clear pulsed mid-burst on beat 2 -> req_ready low next cycle, fifo_clear high exactly one cycle, FSM IDLE after, grant_id unchanged.
REQ-040 Force fifo_full=1 while fifo_wen=1 -> err_overflow=1 and it stays 1 until rst.
REQ-041 rst asserted during GRANT with a valid beat -> next cycle all outputs at reset values and no fifo_wen for that beat.
